// File: rtl/mix_columns_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mix_columns_engine
//  Brief    : Sequential AES MixColumns / InvMixColumns engine, xtime-based,
//             processing COLS_PER_CYCLE columns per clock over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_BUSY      = 2'd1;
    localparam logic [1:0] c_DONE      = 2'd2;
    localparam int         c_BEATS     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] c_LAST_BEAT = 2'(c_BEATS - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    logic [1:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         inv_q, inv_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_state_q, out_state_d;
    logic [127:0] w_beat_result;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (inv) begin
            res = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end else begin
            // 3x is folded in as 2x ^ x.
            res = {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
                   a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
                   a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
                   x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
        end
        return res;
    endfunction

    // Column index wraps to 2 bits so an idle counter never addresses outside the state.
    function automatic int col_msb(input logic [1:0] cnt, input int j);
        logic [1:0] col;
        col = 2'(int'(cnt) * COLS_PER_CYCLE + j);
        return 127 - 32 * int'(col);
    endfunction

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_IDLE;
            cnt_q       <= 2'd0;
            inv_q       <= 1'b0;
            work_q      <= 128'd0;
            out_state_q <= 128'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            work_q      <= work_d;
            out_state_q <= out_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (in_valid)            state_d = c_BUSY;
            c_BUSY:  if (cnt_q == c_LAST_BEAT) state_d = c_DONE;
            c_DONE:  if (out_ready)           state_d = c_IDLE;
            default:                          state_d = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == c_IDLE);
        busy      = (state_q == c_BUSY);
        out_valid = (state_q == c_DONE);
        out_state = out_state_q;
    end

    always_comb begin
        w_beat_result = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_beat_result[col_msb(cnt_q, j) -: 32] = mix_col(work_q[col_msb(cnt_q, j) -: 32], inv_q);
        end
    end

    always_comb begin
        work_d      = work_q;
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        out_state_d = out_state_q;
        case (state_q)
            c_IDLE: begin
                if (in_valid) begin
                    work_d = in_state;
                    inv_d  = in_inv;
                    cnt_d  = 2'd0;
                end
            end
            c_BUSY: begin
                work_d = w_beat_result;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == c_LAST_BEAT) out_state_d = w_beat_result;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mix_columns_engine
//  Brief    : Directed self-checking bench for mix_columns_engine (C = 1, 2, 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_engine;

    localparam logic [127:0] c_VEC_A     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] c_VEC_A_FWD = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] c_VEC_B     = {4{32'hd4bf5d30}};
    localparam logic [127:0] c_VEC_B_FWD = {4{32'h046681e5}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         in_inv    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_state(in_state[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0]));

    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_state(in_state[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1]));

    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_state(in_state[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, input int lat, input logic [127:0] exp, input string tag);
        int n;
        n = 0;
        while (!out_valid[d] && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(lat));
        check({tag, " result"}, out_state[d], exp);
    endtask

    // Accept one block, corrupt the inputs after acceptance, then wait for the result.
    task automatic run_block(input int d, input logic [127:0] st, input logic inv,
                             input logic [127:0] exp, input int lat, input string tag);
        in_state[d] = st;
        in_inv[d]   = inv;
        in_valid[d] = 1'b1;
        out_ready[d] = 1'b0;
        tick();
        in_valid[d] = 1'b0;
        in_inv[d]   = ~inv;
        in_state[d] = '1;
        wait_done(d, lat, exp, tag);
    endtask

    task automatic release_result(input int d, input logic [127:0] exp, input string tag);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check({tag, " out_valid after take"}, 128'(out_valid[d]), 128'd0);
        check({tag, " in_ready after take"}, 128'(in_ready[d]), 128'd1);
        check({tag, " out_state kept"}, out_state[d], exp);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_state[d] = '0; in_inv[d] = 1'b0; out_ready[d] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;

        check("reset out_valid", 128'(out_valid[0]), 128'd0);
        check("reset busy", 128'(busy[0]), 128'd0);
        check("reset in_ready", 128'(in_ready[0]), 128'd1);
        check("reset out_state", out_state[0], 128'd0);

        // Forward, then backpressure while holding the result in DONE.
        run_block(0, c_VEC_A, 1'b0, c_VEC_A_FWD, 4, "c1 fwd");
        in_valid[0] = 1'b1;
        in_state[0] = c_VEC_B;
        in_inv[0]   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("bp out_valid", 128'(out_valid[0]), 128'd1);
        check("bp in_ready", 128'(in_ready[0]), 128'd0);
        check("bp out_state", out_state[0], c_VEC_A_FWD);
        in_valid[0] = 1'b0;
        release_result(0, c_VEC_A_FWD, "c1 fwd");

        run_block(0, c_VEC_A_FWD, 1'b1, c_VEC_A, 4, "c1 inv");
        release_result(0, c_VEC_A, "c1 inv");

        run_block(1, c_VEC_B, 1'b0, c_VEC_B_FWD, 2, "c2 fwd");
        release_result(1, c_VEC_B_FWD, "c2 fwd");
        run_block(2, c_VEC_B, 1'b0, c_VEC_B_FWD, 1, "c4 fwd");
        release_result(2, c_VEC_B_FWD, "c4 fwd");
        run_block(2, c_VEC_B_FWD, 1'b1, c_VEC_B, 1, "c4 inv");
        release_result(2, c_VEC_B, "c4 inv");

        // Reset during beat 2 of a block.
        in_state[0] = c_VEC_B;
        in_inv[0]   = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        check("midop busy before rst", 128'(busy[0]), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop out_valid", 128'(out_valid[0]), 128'd0);
        check("midop busy", 128'(busy[0]), 128'd0);
        check("midop out_state", out_state[0], 128'd0);
        check("midop in_ready", 128'(in_ready[0]), 128'd1);
        run_block(0, c_VEC_A, 1'b0, c_VEC_A_FWD, 4, "post rst fwd");
        release_result(0, c_VEC_A_FWD, "post rst fwd");

        // Back-to-back with in_valid held high and out_ready always asserted.
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_state[0]  = c_VEC_B;
        in_inv[0]    = 1'b0;
        tick();
        in_state[0]  = c_VEC_A_FWD;
        in_inv[0]    = 1'b1;
        wait_done(0, 4, c_VEC_B_FWD, "b2b first");
        tick();
        check("b2b idle in_ready", 128'(in_ready[0]), 128'd1);
        check("b2b idle out_valid", 128'(out_valid[0]), 128'd0);
        tick();
        check("b2b second accepted", 128'(busy[0]), 128'd1);
        in_valid[0] = 1'b0;
        in_inv[0]   = 1'b0;
        wait_done(0, 4, c_VEC_A, "b2b second");
        tick();
        out_ready[0] = 1'b0;
        check("b2b final in_ready", 128'(in_ready[0]), 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Sequential, parametrised MixColumns / InvMixColumns engine for the AES-256 datapath.
- Takes a full 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Selects forward or inverse transform per block, so encryption and decryption share one instance.
- Replaces per-column table lookups with xtime-based GF(2^8) arithmetic.

Parameters:
- COLS_PER_CYCLE, 1, columns processed per clock; legal values 1, 2, 4 only; any other value must fail at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input state presented
- in_ready  output  1  engine can accept a state
- in_state  input  128  state; column c = bits [127-32c -: 32]; row 0 = MSB byte of each column
- in_inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_state
- out_valid  output  1  out_state holds a finished result
- out_ready  input  1  downstream accepts the result
- out_state  output  128  transformed state, same byte layout as in_state
- busy  output  1  high while in BUSY

Behaviour:
- Reset (rst=1 at a clk edge): state = IDLE, beat counter = 0, work register = 0, out_state = 0, out_valid = 0, busy = 0, in_ready = 1 from the following cycle. Reset overrides all other activity, including mid-operation; any partial result is discarded.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_state into the work register, latch in_inv, clear the counter, go to BUSY.
- FSM BUSY:
  - in_ready = 0, busy = 1.
  - Each cycle, transform columns k*C .. k*C+C-1 in place (C = COLS_PER_CYCLE, k = counter), then increment the counter.
  - After beat 4/C-1, go to DONE.
- FSM DONE:
  - out_valid = 1 and out_state = work register.
  - out_state stays stable while out_valid=1 & out_ready=0.
  - On out_ready: go to IDLE; out_valid drops next cycle.
  - out_state keeps its last value after the result is taken.
- Throughput and latency:
  - No overlap: in_ready = 0 in BUSY and DONE. A new input may only be accepted the cycle after a DONE handshake.
  - Latency from the acceptance edge to out_valid high is 4/C cycles: C=1 gives 4, C=2 gives 2, C=4 gives 1. out_valid asserts on the edge that completes the last beat.
- Forward transform, column bytes a0..a3 (a0 = MSB):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse transform:
  - b0 = e·a0^b·a1^d·a2^9·a3, with each following row rotated right (rows 1–3 use the same coefficients shifted one position per row).
- GF arithmetic:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - 9x, bx, dx, ex are formed as XOR chains of x, xtime(x), xtime²(x) and xtime³(x).
  - Purely combinational within a beat; no lookup tables.
- The mode bit is held for the whole block. in_inv changes after acceptance have no effect.
- in_state is ignored outside the IDLE handshake.

Test Plan:
- C=1, fwd, in_state=db135345_f20a225c_01010101_c6c6c6c6 -> after 4 cycles out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid=1.
- C=1, inv, in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_state=db135345_f20a225c_01010101_c6c6c6c6; the round trip restores the input exactly.
- C=4, fwd, column d4bf5d30 in all four columns -> out_valid 1 cycle after acceptance, out_state=046681e5 repeated 4 times. C=2 with the same input -> latency 2.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst in BUSY beat 2 -> next cycle out_valid=0, busy=0, out_state=0, in_ready=1. A fresh fwd block then gives the correct result with no stale columns.
- Back-to-back: keep in_valid=1 with two states (fwd then inv) and out_ready=1 -> both results correct, the second accepted the cycle after the first DONE handshake, with in_inv captured per block.
